// File: rtl/reg_file_pw_if.sv
// Register file bus: write port, two read ports, clear request, ready.
// Master drives the request side; slave is the register file.
interface reg_file_pw_if #(
    parameter int DW = 8,
    parameter int PW = 3
);
    logic          clr;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [DW-1:0] dat_in;
    logic [PW-1:0] rd_addrA;
    logic [PW-1:0] rd_addrB;
    logic [DW-1:0] datA_out;
    logic [DW-1:0] datB_out;
    logic          ready;

    modport master (
        output clr, wr_en, wr_addr, dat_in, rd_addrA, rd_addrB,
        input  datA_out, datB_out, ready
    );

    modport slave (
        input  clr, wr_en, wr_addr, dat_in, rd_addrA, rd_addrB,
        output datA_out, datB_out, ready
    );
endinterface

// File: rtl/reg_file_pw.sv
// Parametrised 2R/1W register file with a one-entry-per-cycle clear
// sweep after reset or clear request, optional bypass and zero register.
module reg_file_pw #(
    parameter int DW      = 8,
    parameter int PW      = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_file_pw_if.slave    bus
);
    localparam int DEPTH = 2 ** PW;

    typedef enum logic {
        SWEEP,
        READY
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_idx;
    logic [PW-1:0]   w_idx_nxt;
    logic [DW-1:0]   r_core [DEPTH];
    logic            w_sweep_wr;
    logic            w_wr;
    logic            w_byp_ok;
    logic [DW-1:0]   w_datA;
    logic [DW-1:0]   w_datB;

    // State and sweep index register; reset restarts the sweep at entry 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SWEEP;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: sweep clears one entry per edge, clear beats write
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sweep_wr  = 1'b0;
        w_wr        = 1'b0;
        unique case (r_state)
            SWEEP: begin
                w_sweep_wr = 1'b1;
                w_idx_nxt  = r_idx + 1'b1;
                if (r_idx == PW'(DEPTH - 1))
                    w_state_nxt = READY;
            end
            READY: begin
                if (bus.clr) begin
                    w_state_nxt = SWEEP;
                    w_idx_nxt   = '0;
                end else if (bus.wr_en) begin
                    w_wr = !((ZERO_R0 != 0) && (bus.wr_addr == '0));
                end
            end
        endcase
    end

    // Storage update; contents are left alone on the reset edge itself
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_sweep_wr)
                r_core[r_idx] <= '0;
            else if (w_wr)
                r_core[bus.wr_addr] <= bus.dat_in;
        end
    end

    assign w_byp_ok = (BYPASS != 0) && (r_state == READY)
                      && bus.wr_en && !bus.clr;

    // Read port A: zero during sweep, zero register first, then bypass
    always_comb begin
        w_datA = r_core[bus.rd_addrA];
        if (r_state != READY)
            w_datA = '0;
        else if ((ZERO_R0 != 0) && (bus.rd_addrA == '0))
            w_datA = '0;
        else if (w_byp_ok && (bus.rd_addrA == bus.wr_addr))
            w_datA = bus.dat_in;
    end

    // Read port B: same priority as port A
    always_comb begin
        w_datB = r_core[bus.rd_addrB];
        if (r_state != READY)
            w_datB = '0;
        else if ((ZERO_R0 != 0) && (bus.rd_addrB == '0))
            w_datB = '0;
        else if (w_byp_ok && (bus.rd_addrB == bus.wr_addr))
            w_datB = bus.dat_in;
    end

    assign bus.datA_out = w_datA;
    assign bus.datB_out = w_datB;
    assign bus.ready    = (r_state == READY);
endmodule

// File: tb/tb_reg_file_pw.sv
// Directed bench for reg_file_pw: three instances cover bypass on/off
// and a 16-bit, 16-entry file with a hardwired zero register.
module tb_reg_file_pw;
    logic clk = 1'b0;
    logic rst0_n;
    logic rst1_n;
    logic rst2_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   c0;
    int   c1;
    int   c2;

    always #5 clk = ~clk;

    reg_file_pw_if #(.DW(8),  .PW(3)) b0 ();
    reg_file_pw_if #(.DW(8),  .PW(3)) b1 ();
    reg_file_pw_if #(.DW(16), .PW(4)) b2 ();

    reg_file_pw #(.DW(8), .PW(3), .BYPASS(1), .ZERO_R0(0)) u0 (
        .clk(clk), .rst_n(rst0_n), .bus(b0.slave)
    );
    reg_file_pw #(.DW(8), .PW(3), .BYPASS(0), .ZERO_R0(0)) u1 (
        .clk(clk), .rst_n(rst1_n), .bus(b1.slave)
    );
    reg_file_pw #(.DW(16), .PW(4), .BYPASS(1), .ZERO_R0(1)) u2 (
        .clk(clk), .rst_n(rst2_n), .bus(b2.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
        b0.clr = 0; b0.wr_en = 1; b0.wr_addr = 3; b0.dat_in = 8'hAA;
        b0.rd_addrA = 3; b0.rd_addrB = 0;
        b1.clr = 0; b1.wr_en = 0; b1.wr_addr = 0; b1.dat_in = 0;
        b1.rd_addrA = 0; b1.rd_addrB = 0;
        b2.clr = 0; b2.wr_en = 0; b2.wr_addr = 0; b2.dat_in = 0;
        b2.rd_addrA = 0; b2.rd_addrB = 0;

        // reset held two edges, then sweep lengths
        tick();
        tick();
        check("rst_ready", b0.ready, 0);
        check("rst_datA", b0.datA_out, 0);
        rst0_n = 1; rst1_n = 1; rst2_n = 1;
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 4) check("sweep_datA", b0.datA_out, 0);
            if (c0 == 0 && b0.ready) begin
                c0 = k;
                b0.wr_en = 0;
            end
            if (c1 == 0 && b1.ready) c1 = k;
            if (c2 == 0 && b2.ready) c2 = k;
        end
        check("sweep_len8", c0, 8);
        check("sweep_len8_u1", c1, 8);
        check("sweep_len16", c2, 16);
        for (int a = 0; a < 8; a++) begin
            b0.rd_addrA = 3'(a);
            #1;
            check($sformatf("swept_%0d", a), b0.datA_out, 0);
        end

        // write/read and dual port, no bypass
        b1.wr_en = 1; b1.wr_addr = 2; b1.dat_in = 8'h5A;
        tick();
        b1.wr_addr = 7; b1.dat_in = 8'hC3;
        tick();
        b1.wr_en = 0; b1.rd_addrA = 2; b1.rd_addrB = 7;
        #1;
        check("rdA_2", b1.datA_out, 8'h5A);
        check("rdB_7", b1.datB_out, 8'hC3);
        b1.rd_addrA = 7;
        #1;
        check("same_A", b1.datA_out, 8'hC3);
        check("same_B", b1.datB_out, 8'hC3);

        // bypass on u0, none on u1
        b0.wr_en = 1; b0.wr_addr = 4; b0.dat_in = 8'h11;
        b1.wr_en = 1; b1.wr_addr = 4; b1.dat_in = 8'h11;
        tick();
        b0.dat_in = 8'h99; b0.rd_addrA = 4;
        b1.dat_in = 8'h99; b1.rd_addrA = 4;
        #1;
        check("byp_on", b0.datA_out, 8'h99);
        check("byp_off", b1.datA_out, 8'h11);
        tick();
        b0.wr_en = 0; b1.wr_en = 0;
        #1;
        check("byp_off_next", b1.datA_out, 8'h99);
        check("byp_on_next", b0.datA_out, 8'h99);

        // clr against write, second clr mid-sweep ignored
        b1.clr = 1; b1.wr_en = 1; b1.wr_addr = 5; b1.dat_in = 8'h77;
        tick();
        b1.clr = 0; b1.wr_en = 0;
        check("clr_ready0", b1.ready, 0);
        c1 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) b1.clr = 1;
            if (k == 3) b1.clr = 0;
            if (c1 == 0 && b1.ready) c1 = k;
        end
        check("clr_len", c1, 8);
        b1.rd_addrA = 5; b1.rd_addrB = 2;
        #1;
        check("clr_a5", b1.datA_out, 0);
        check("clr_a2", b1.datB_out, 0);

        // reset at idx=5 restarts the sweep
        b0.clr = 1;
        tick();
        b0.clr = 0;
        for (int k = 0; k < 5; k++) tick();
        rst0_n = 0;
        tick();
        check("mid_rst_ready", b0.ready, 0);
        rst0_n = 1;
        c0 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (c0 == 0 && b0.ready) c0 = k;
        end
        check("mid_rst_len", c0, 8);
        b0.rd_addrA = 4;
        #1;
        check("mid_rst_a4", b0.datA_out, 0);

        // zero register on u2
        b2.wr_en = 1; b2.wr_addr = 0; b2.dat_in = 16'hBEEF;
        tick();
        b2.wr_addr = 15; b2.dat_in = 16'h1234;
        tick();
        b2.wr_en = 0; b2.rd_addrA = 0; b2.rd_addrB = 15;
        #1;
        check("z_rd0", b2.datA_out, 0);
        check("z_rd15", b2.datB_out, 16'h1234);
        b2.wr_en = 1; b2.wr_addr = 0; b2.dat_in = 16'hBEEF;
        #1;
        check("z_byp0", b2.datA_out, 0);
        b2.wr_addr = 15; b2.dat_in = 16'h5555;
        #1;
        check("z_byp15", b2.datB_out, 16'h5555);
        b2.wr_en = 0;
        #1;
        check("z_hold15", b2.datB_out, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
